serial_adder_n: RTL and testbench

Parametrised bit-serial adder/subtractor for the Nexys4 DDR lab designs. It generalises the 2-bit ripple full-adder to WIDTH bits. A single registered full-adder stage and a carry flip-flop process one bit per clock, LSB first. Operands come from board switches or upstream logic through a start/busy/done handshake. Results, carry-out and signed overflow are held for display on LEDs.

---
 rtl/serial_adder_n.sv | 116 +++++++++++
 tb/tb_serial_adder_n.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | serial_adder_n : bit-serial WIDTH-bit adder/subtractor, LSB first,      |
// |                  start/busy/done handshake.  Rev 1.0                     |
// +-------------------------------------------------------------------------+
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             w_bit_sum;
  logic             w_bit_carry;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign w_bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {w_bit_sum, sum_q[WIDTH-1:1]};
        carry_d = w_bit_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          cout_d  = w_bit_carry;
          ovf_d   = carry_q ^ w_bit_carry;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_n.sv
`default_nettype none
// Self-checking bench for serial_adder_n: WIDTH=8 and WIDTH=2 instances
// checked every cycle against an arithmetic reference model.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       st2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  serial_adder_n #(.WIDTH(8)) u_dut8 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(st8), .sub(sub8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  serial_adder_n #(.WIDTH(2)) u_dut2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(st2), .sub(sub2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .ovf(ovf2)
  );

  int total = 0;
  int bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on integers: modular result, unsigned carry/borrow,
  // and signed range overflow.
  task automatic ref_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input bit s, output logic [31:0] rs, output bit rc, output bit rv);
    longint ua, ub, r, sa, sb, sr, m;
    m  = longint'(1) << w;
    ua = longint'(av);
    ub = longint'(bv);
    r  = s ? ua - ub : ua + ub;
    rs = 32'((r % m + m) % m);
    rc = s ? (ua >= ub) : (r >= m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = s ? sa - sb : sa + sb;
    rv = (sr < -(m / 2)) || (sr > m / 2 - 1);
  endtask

  int          rem[2]    = '{0, 0};
  bit          e_done[2] = '{0, 0};
  logic [31:0] e_sum[2]  = '{0, 0};
  bit          e_cout[2] = '{0, 0};
  bit          e_ovf[2]  = '{0, 0};
  logic [31:0] p_sum[2]  = '{0, 0};
  bit          p_cout[2] = '{0, 0};
  bit          p_ovf[2]  = '{0, 0};

  task automatic model_step(input int i, input int w, input bit st,
                            input logic [31:0] av, input logic [31:0] bv, input bit s);
    logic [31:0] rs;
    bit rc, rv;
    e_done[i] = 1'b0;
    if (rem[i] > 0) begin
      rem[i]--;
      if (rem[i] == 0) begin
        e_done[i] = 1'b1;
        e_sum[i]  = p_sum[i];
        e_cout[i] = p_cout[i];
        e_ovf[i]  = p_ovf[i];
      end
    end else if (st) begin
      ref_op(w, av, bv, s, rs, rc, rv);
      p_sum[i]  = rs;
      p_cout[i] = rc;
      p_ovf[i]  = rv;
      rem[i]    = w;
    end
  endtask

  task automatic model_reset(input int i);
    rem[i] = 0; e_done[i] = 0; e_sum[i] = 0; e_cout[i] = 0; e_ovf[i] = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 8, st8, 32'(a8), 32'(b8), sub8);
      model_step(1, 2, st2, 32'(a2), 32'(b2), sub2);
    end
  end

  // Results are only meaningful while idle; busy and done always are.
  task automatic check_inst(input int i, input string tag, input logic bz, input logic dn,
                            input logic [31:0] sm, input logic co, input logic ov);
    cmp({tag, "_busy"}, 32'(bz), 32'(rem[i] > 0));
    cmp({tag, "_done"}, 32'(dn), 32'(e_done[i]));
    if (rem[i] == 0) begin
      cmp({tag, "_sum"},  sm, e_sum[i]);
      cmp({tag, "_cout"}, 32'(co), 32'(e_cout[i]));
      cmp({tag, "_ovf"},  32'(ov), 32'(e_ovf[i]));
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_inst(0, "w8", busy8, done8, 32'(sum8), cout8, ovf8);
    check_inst(1, "w2", busy2, done2, 32'(sum2), cout2, ovf2);
  end

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                      input logic [7:0] xs, input logic xc, input logic xv);
    int lat;
    @(negedge clk);
    a8 = av; b8 = bv; sub8 = s; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    lat = 0;
    while (!done8 && lat <= 20) begin
      @(negedge clk);
      lat++;
    end
    cmp("lit8_latency", 32'(lat), 32'd8);
    cmp("lit8_sum", 32'(sum8), 32'(xs));
    cmp("lit8_cout", 32'(cout8), 32'(xc));
    cmp("lit8_ovf", 32'(ovf8), 32'(xv));
  endtask

  task automatic run2(input logic [1:0] av, input logic [1:0] bv, input logic s);
    int lat;
    @(negedge clk);
    a2 = av; b2 = bv; sub2 = s; st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0;
    lat = 0;
    while (!done2 && lat <= 10) begin
      @(negedge clk);
      lat++;
    end
    cmp("w2_latency", 32'(lat), 32'd2);
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    cmp("rst_busy", 32'(busy8), 32'd0);
    cmp("rst_done", 32'(done8), 32'd0);
    cmp("rst_sum", 32'(sum8), 32'd0);
    cmp("rst_cout", 32'(cout8), 32'd0);
    cmp("rst_ovf", 32'(ovf8), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run8(8'd3, 8'd2, 1'b0, 8'd5, 1'b0, 1'b0);
    run8(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    run8(8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
    run8(8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0);
    run8(8'h80, 8'd1, 1'b1, 8'h7F, 1'b1, 1'b1);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        run2(2'(x), 2'(y), 1'b0);
    run2(2'd3, 2'd3, 1'b0);
    cmp("lit2_sum", 32'(sum2), 32'd2);
    cmp("lit2_cout", 32'(cout2), 32'd1);
    repeat (16) run2(2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));

    // A start pulse while busy must be dropped entirely.
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    ndone = 0;
    for (int i = 4; i <= 14; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        cmp("busy_start_done_cycle", 32'(i), 32'd8);
        cmp("busy_start_sum", 32'(sum8), 32'd30);
      end
    end
    cmp("busy_start_ndone", 32'(ndone), 32'd1);

    // Asynchronous abort mid-operation.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd50; sub8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    cmp("abort_busy_before", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    cmp("abort_busy", 32'(busy8), 32'd0);
    cmp("abort_done", 32'(done8), 32'd0);
    cmp("abort_sum", 32'(sum8), 32'd0);
    cmp("abort_cout", 32'(cout8), 32'd0);
    cmp("abort_ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'd100, 8'd50, 1'b0, 8'd150, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom_range(0, 1)); st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(6, 11)) @(negedge clk);
    end

    // Held start: back-to-back operations on whatever inputs are present.
    st8 = 1'b1;
    repeat (40) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom_range(0, 1));
    end
    st8 = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
